// File: rtl/dmem_sram_bridge_pkg.sv
// dmem_sram_bridge_pkg: shared memory-stage request types, bus request record and FSM states
package dmem_sram_bridge_pkg;
  localparam logic [1:0] MSIZE_B = 2'b00;
  localparam logic [1:0] MSIZE_H = 2'b01;
  localparam logic [1:0] MSIZE_W = 2'b10;
  typedef struct packed {
    logic        ren;
    logic [31:0] addr;
    logic [1:0]  size;
  } m_r_t;
  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
  } m_w_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dbus_state_t;
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;
endpackage

// File: rtl/dmem_sram_bridge.sv
// dmem_sram_bridge: memory-stage data port to SRAM-like bus master with pipeline stall and timeout flag
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  m_r_t        mread,
  input  m_w_t        mwrite,
  output logic [31:0] rd,
  output logic        stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        timeout
);
  dbus_state_t state_q, state_d;
  dbus_req_t   req_q, req_d, sel, cur;
  logic [31:0] rd_q, rd_d, cnt_q, cnt_d;
  logic        timeout_q, timeout_d, valid, busy;
  always_comb begin
    valid = mread.ren | mwrite.wen;
    sel = mwrite.wen ? {1'b1, mwrite.size, mwrite.addr, mwrite.wd}
                     : {1'b0, mread.size, mread.addr, 32'h0};
    // in IDLE the bus sees the live request; afterwards the latched copy keeps it stable
    cur = state_q == IDLE ? sel : req_q;
    req_d = cur;
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = data_addr_ok ? (data_data_ok ? DONE : WAIT) : REQ;
      REQ:     if (data_addr_ok) state_d = data_data_ok ? DONE : WAIT;
      WAIT:    if (data_data_ok) state_d = DONE;
      default: state_d = IDLE;
    endcase
    rd_d = (state_d == DONE && state_q != DONE && !cur.wr) ? data_rdata : rd_q;
    busy = state_q == REQ || state_q == WAIT;
    cnt_d = !busy ? 32'h0 : (&cnt_q ? cnt_q : cnt_q + 32'd1);
    timeout_d = timeout_q | (TIMEOUT_CYCLES != 0 && cnt_d >= TIMEOUT_CYCLES);
    stall = resetn & ((valid & state_q != DONE) | busy);
    data_req = resetn & ((state_q == IDLE & valid) | state_q == REQ);
    data_wr = resetn & cur.wr;
    data_size = resetn ? cur.size : 2'b00;
    data_addr = resetn ? cur.addr : 32'h0;
    data_wdata = resetn ? cur.wdata : 32'h0;
    rd = rd_q;
    timeout = timeout_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_dmem_sram_bridge.sv
// tb_dmem_sram_bridge: directed scoreboard bench for the data-memory bridge
module tb_dmem_sram_bridge;
  import dmem_sram_bridge_pkg::*;
  logic        clk = 1'b0, resetn = 1'b0;
  m_r_t        mread = '0, nr = '0;
  m_w_t        mwrite = '0, nw = '0;
  logic [31:0] rd, data_addr, data_wdata, data_rdata = 32'h0, rd_m = 32'h0;
  logic        stall, data_req, data_wr, data_addr_ok = 1'b0, data_data_ok = 1'b0, timeout;
  logic [1:0]  data_size;
  int          ncmp = 0, nerr = 0, nacc = 0, nreq = 0, a0, r0;
  bit          busy = 1'b0;
  dbus_req_t   busq[$];
  logic [31:0] rdq[$];
  always #5 clk = ~clk;
  dmem_sram_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .resetn(resetn), .mread(mread), .mwrite(mwrite), .rd(rd), .stall(stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd_req(input logic [31:0] a, input logic [1:0] s);
    dbus_req_t e;
    nr = '{ren: 1'b1, addr: a, size: s};
    nw = '0;
    e = '{wr: 1'b0, size: s, addr: a, wdata: 32'h0};
    busq.push_back(e);
  endtask
  task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    dbus_req_t e;
    nw = '{wen: 1'b1, addr: a, wd: d, size: s};
    nr = '0;
    e = '{wr: 1'b1, size: s, addr: a, wdata: d};
    busq.push_back(e);
  endtask
  // one cycle: drive inputs at negedge, then monitor outputs; DONE is seen as stall dropping after acceptance
  task automatic cyc(input logic aok, input logic dok, input logic [31:0] rdat);
    dbus_req_t e;
    @(negedge clk);
    mread = nr;
    mwrite = nw;
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata = rdat;
    #1;
    if (busy && !stall) begin
      chk("rd_pending", 32'(rdq.size() != 0), 32'd1);
      if (rdq.size() != 0) chk("rd_done", rd, rdq.pop_front());
      busy = 1'b0;
    end
    if (data_req) nreq++;
    if (data_req && data_addr_ok) begin
      chk("bus_pending", 32'(busq.size() != 0), 32'd1);
      if (busq.size() != 0) begin
        e = busq.pop_front();
        chk("bus_wr", 32'(data_wr), 32'(e.wr));
        chk("bus_size", 32'(data_size), 32'(e.size));
        chk("bus_addr", data_addr, e.addr);
        if (e.wr) chk("bus_wdata", data_wdata, e.wdata);
      end
      busy = 1'b1;
      nacc++;
    end
  endtask
  initial begin
    #2;
    chk("rst_rd", rd, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, 1'b0, 32'h0);
    // read, addr_ok immediately, data_ok one cycle later
    rd_req(32'h0000_1004, MSIZE_W);
    rdq.push_back(32'hDEADBEEF);
    rd_m = 32'hDEADBEEF;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t1_req_idle", 32'(data_req), 32'd1);
    chk("t1_stall_idle", 32'(stall), 32'd1);
    cyc(1'b0, 1'b1, 32'hDEADBEEF);
    chk("t1_req_wait", 32'(data_req), 32'd0);
    chk("t1_stall_wait", 32'(stall), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t1_stall_done", 32'(stall), 32'd0);
    chk("t1_rd_done", rd, 32'hDEADBEEF);
    chk("t1_timeout", 32'(timeout), 32'd0);
    nr = '0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("t1_no_reissue", 32'(data_req), 32'd0);
    chk("t1_stall_idle2", 32'(stall), 32'd0);
    // byte write with delayed addr_ok while the stage changes its address
    wr_req(32'h0000_2003, 32'h0000_00AB, MSIZE_B);
    rdq.push_back(rd_m);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t2_wr_idle", 32'(data_wr), 32'd1);
    chk("t2_stall_idle", 32'(stall), 32'd1);
    nw.addr = 32'h0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("t2_req", 32'(data_req), 32'd1);
      chk("t2_addr_hold", data_addr, 32'h0000_2003);
      chk("t2_wr_hold", 32'(data_wr), 32'd1);
      chk("t2_wdata", data_wdata, 32'h0000_00AB);
    end
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF);
    chk("t2_addr_acc", data_addr, 32'h0000_2003);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t2_stall_done", 32'(stall), 32'd0);
    chk("t2_rd_kept", rd, 32'hDEADBEEF);
    nw = '0;
    cyc(1'b0, 1'b0, 32'h0);
    // zero-wait slave
    rd_req(32'h0000_3000, MSIZE_W);
    rdq.push_back(32'h1234_5678);
    rd_m = 32'h1234_5678;
    cyc(1'b1, 1'b1, 32'h1234_5678);
    chk("t3_stall", 32'(stall), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t3_stall_done", 32'(stall), 32'd0);
    chk("t3_rd", rd, 32'h1234_5678);
    nr = '0;
    cyc(1'b0, 1'b0, 32'h0);
    // back-to-back read then write
    a0 = nacc;
    r0 = nreq;
    rd_req(32'h0000_4000, MSIZE_W);
    rdq.push_back(32'hCAFE_F00D);
    rd_m = 32'hCAFE_F00D;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_stall_r0", 32'(stall), 32'd1);
    cyc(1'b0, 1'b1, 32'hCAFE_F00D);
    chk("t4_stall_r1", 32'(stall), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t4_stall_rdone", 32'(stall), 32'd0);
    wr_req(32'h0000_5000, 32'h0000_55AA, MSIZE_W);
    rdq.push_back(rd_m);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_stall_w0", 32'(stall), 32'd1);
    cyc(1'b0, 1'b1, 32'h0);
    chk("t4_stall_w1", 32'(stall), 32'd1);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t4_stall_wdone", 32'(stall), 32'd0);
    chk("t4_rd_kept", rd, 32'hCAFE_F00D);
    nw = '0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("t4_accepts", 32'(nacc - a0), 32'd2);
    chk("t4_req_cycles", 32'(nreq - r0), 32'd2);
    // reset while waiting for data
    rd_req(32'h0000_6000, MSIZE_W);
    cyc(1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t5_stall_wait", 32'(stall), 32'd1);
    resetn = 1'b0;
    nr = '0;
    mread = '0;
    busy = 1'b0;
    #1;
    chk("t5_stall_rst", 32'(stall), 32'd0);
    chk("t5_req_rst", 32'(data_req), 32'd0);
    chk("t5_rd_rst", rd, 32'h0);
    #1;
    resetn = 1'b1;
    cyc(1'b0, 1'b1, 32'hBAD0_BAD0);
    cyc(1'b0, 1'b0, 32'h0);
    chk("t5_late_rd", rd, 32'h0);
    chk("t5_late_stall", 32'(stall), 32'd0);
    chk("t5_late_req", 32'(data_req), 32'd0);
    chk("busq_empty", 32'(busq.size()), 32'd0);
    chk("rdq_empty", 32'(rdq.size()), 32'd0);
    // slave never accepts: timeout after four REQ cycles, sticky
    chk("t6_timeout_init", 32'(timeout), 32'd0);
    nr = '{ren: 1'b1, addr: 32'h0000_7000, size: MSIZE_W};
    cyc(1'b0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("t6_timeout_low", 32'(timeout), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("t6_timeout_high", 32'(timeout), 32'd1);
      chk("t6_stall", 32'(stall), 32'd1);
    end
    nr = '0;
    cyc(1'b0, 1'b0, 32'h0);
    chk("t6_stall_req", 32'(stall), 32'd1);
    chk("t6_timeout_sticky", 32'(timeout), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
